rggen_bus_host_arbiter: RTL
===========================

Name: rggen_bus_host_arbiter

Overview:
- Shares one downstream register-block bus between HOSTS upstream requesters. Typical requesters: CPU bridge, debug port, DMA.
- Round-robin arbitration with exactly one transaction in flight.
- Each command is latched and replayed to the downstream rggen bus. The response is returned to the granted host only.
- Optional timeout converts a hung downstream access into RGGEN_SLAVE_ERROR.

Parameters:
- HOSTS, 2: number of upstream requesters (>=1).
- ADDRESS_WIDTH, 16: byte address width.
- BUS_WIDTH, 32: data width; strobe width is BUS_WIDTH/8.
- TIMEOUT_CYCLES, 0: downstream wait limit in cycles. 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_host_valid  in  HOSTS  per-host request valid; held until o_host_ready.
- i_host_access  in  HOSTS x 2  rggen_access per host.
- i_host_address  in  HOSTS x ADDRESS_WIDTH  per-host address.
- i_host_write_data  in  HOSTS x BUS_WIDTH  per-host write data.
- i_host_strobe  in  HOSTS x BUS_WIDTH/8  per-host byte strobe.
- o_host_ready  out  HOSTS  one-cycle completion pulse to the granted host.
- o_host_status  out  HOSTS x 2  rggen_status, valid with o_host_ready.
- o_host_read_data  out  HOSTS x BUS_WIDTH  read data, valid with o_host_ready.
- o_valid  out  1  downstream request.
- o_access  out  2  downstream access.
- o_address  out  ADDRESS_WIDTH  downstream address.
- o_write_data  out  BUS_WIDTH  downstream write data.
- o_strobe  out  BUS_WIDTH/8  downstream strobe.
- i_ready  in  1  downstream completion.
- i_status  in  2  downstream status.
- i_read_data  in  BUS_WIDTH  downstream read data.
- o_grant  out  HOSTS  one-hot index of the host owning the bus; 0 in IDLE.

Behaviour:
- Clock, reset and state encoding:
  - All state is updated on the i_clk rising edge.
  - i_rst synchronous, active-high.
  - States: IDLE, BUSY, RESP.
- Reset values:
  - State IDLE; round-robin pointer at host 0 (highest priority); timeout counter 0.
  - All outputs 0: o_valid, o_grant, o_host_ready, o_host_status, o_host_read_data, o_access, o_address, o_write_data, o_strobe.
- IDLE:
  - If any i_host_valid is set, pick the first set bit searching from the pointer upward, wrapping modulo HOSTS.
  - Latch that host's access, address, write_data and strobe, set o_grant, and go to BUSY.
  - If no request is pending, stay in IDLE.
- BUSY:
  - o_valid=1 and o_access/o_address/o_write_data/o_strobe are driven from the latched copy, stable throughout the state.
  - The timeout counter increments each cycle.
  - On i_ready: capture i_status and i_read_data, go to RESP.
  - Read data is captured for all accesses; it is zeroed on a write.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without i_ready: capture RGGEN_SLAVE_ERROR with read_data 0, go to RESP.
  - A timed-out access is abandoned: o_valid drops in RESP, and any late i_ready is ignored.
- RESP:
  - o_valid=0.
  - For one cycle, o_host_ready[g]=1 with the captured status and data on lane g; all other lanes are 0.
  - Pointer becomes (g+1) mod HOSTS; counter cleared; o_grant cleared; go to IDLE.
- Latency:
  - A request accepted in IDLE at cycle t drives o_valid from t+1.
  - i_ready at cycle k gives o_host_ready at k+1.
  - A 1-cycle downstream access completes in 3 cycles; the minimum host-to-host gap is one IDLE cycle.
- Posted writes (RGGEN_POSTED_WRITE) are forwarded unchanged; completion still waits for i_ready.
- A host dropping i_host_valid mid-transaction does not abort it. The transaction completes and the ready pulse is still issued.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority after reset.
- i_ready while not in BUSY is ignored.
- Reset asserted in BUSY or RESP returns to IDLE next cycle with o_valid=0 and no ready pulse.
- HOSTS=1 degenerates to a registered pass-through, with the pointer constant 0.

Decomposition:
- Add to the shared rtl package:
  - rggen_arbiter_state enum (IDLE/BUSY/RESP).
  - rggen_clip_width-style helper for the counter width: clog2(TIMEOUT_CYCLES+1), minimum 1.
- rggen_access and rggen_status are reused from the package.
- One sub-module: rggen_round_robin_arbiter.
  - Parameter HOSTS; combinational one-hot pick from request and pointer.
  - Registered pointer, updated on a completion pulse.

Test Plan:
- Single host 0 read at 0x0010, i_ready one cycle after o_valid with data 0xCAFEF00D, status OKAY -> o_host_ready[0] at cycle 3, o_host_read_data[0]=0xCAFEF00D, o_host_status[0]=RGGEN_OKAY.
- Hosts 0 and 1 request continuously from reset -> grants alternate 0,1,0,1; o_valid is never high in IDLE.
- Host 1 write 0x12345678 to 0x0020 with strobe 0xF -> o_access=RGGEN_WRITE, o_address=0x0020, o_write_data=0x12345678 held stable during BUSY until i_ready.
- TIMEOUT_CYCLES=8, downstream never ready -> o_valid high for exactly 8 cycles, then o_host_ready with RGGEN_SLAVE_ERROR and data 0; a late i_ready afterwards produces no extra pulse.
- i_rst asserted in BUSY -> next cycle o_valid=0, o_grant=0, no o_host_ready; after release, host 0 wins a simultaneous request from hosts 0 and 1.
- Downstream returns RGGEN_DECODE_ERROR on a RGGEN_POSTED_WRITE -> that status is forwarded unchanged to the requesting host.

Source files
------------

// File: rtl/rggen_bus_host_arbiter_pkg.sv
// Shared types and helpers for the rggen bus host arbiter slice.
package rggen_bus_host_arbiter_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b10,
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } rggen_arbiter_state;

  // Width needed to hold values below 'value', never narrower than one bit.
  function automatic int rggen_clip_width(int value);
    if (value > 1) begin
      return $clog2(value);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rggen_bus_host_arbiter_round_robin.sv
// Round-robin picker: one-hot grant from the request vector starting at the
// pointer; the pointer moves past the served host when its response completes.
module rggen_round_robin_arbiter
  import rggen_bus_host_arbiter_pkg::*;
#(
  parameter int HOSTS = 2
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [HOSTS-1:0] i_request,
  input  logic             i_done,
  input  logic [HOSTS-1:0] i_done_grant,
  output logic [HOSTS-1:0] o_grant
);

  localparam int PW = rggen_clip_width(HOSTS);

  logic [PW-1:0]    pointer_r;
  logic [PW-1:0]    pointer_next_s;
  logic [HOSTS-1:0] candidate_s;
  int               pick_idx_s;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_grant     = '0;
    candidate_s = '0;
    pick_idx_s  = 0;
    for (int k = HOSTS - 1; k >= 0; k--) begin
      pick_idx_s  = (int'(pointer_r) + k) % HOSTS;
      candidate_s = HOSTS'(1'b1) << pick_idx_s;
      if (|(i_request & candidate_s)) begin
        o_grant = candidate_s;
      end else begin
        o_grant = o_grant;
      end
    end
  end

  // Next pointer is the host just after the one that completed.
  always_comb begin
    pointer_next_s = pointer_r;
    for (int h = 0; h < HOSTS; h++) begin
      if (i_done_grant[h]) begin
        pointer_next_s = (h == HOSTS - 1) ? PW'(1'b0) : PW'(h + 1);
      end else begin
        pointer_next_s = pointer_next_s;
      end
    end
  end

  // Pointer register, advanced only on a completion pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pointer_r <= '0;
    end else if (i_done) begin
      pointer_r <= pointer_next_s;
    end
  end

endmodule

// File: rtl/rggen_bus_host_arbiter.sv
// Shares one downstream rggen bus between HOSTS requesters, one transaction
// at a time, with an optional timeout that turns a hung access into an error.
module rggen_bus_host_arbiter
  import rggen_bus_host_arbiter_pkg::*;
#(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [HOSTS-1:0]                     i_host_valid,
  input  logic [HOSTS-1:0][1:0]                i_host_access,
  input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0]  i_host_address,
  input  logic [HOSTS-1:0][BUS_WIDTH-1:0]      i_host_write_data,
  input  logic [HOSTS-1:0][BUS_WIDTH/8-1:0]    i_host_strobe,
  output logic [HOSTS-1:0]                     o_host_ready,
  output logic [HOSTS-1:0][1:0]                o_host_status,
  output logic [HOSTS-1:0][BUS_WIDTH-1:0]      o_host_read_data,
  output logic                                 o_valid,
  output logic [1:0]                           o_access,
  output logic [ADDRESS_WIDTH-1:0]             o_address,
  output logic [BUS_WIDTH-1:0]                 o_write_data,
  output logic [BUS_WIDTH/8-1:0]               o_strobe,
  input  logic                                 i_ready,
  input  logic [1:0]                           i_status,
  input  logic [BUS_WIDTH-1:0]                 i_read_data,
  output logic [HOSTS-1:0]                     o_grant
);

  localparam int STRB_W  = BUS_WIDTH / 8;
  localparam int COUNT_W = rggen_clip_width(TIMEOUT_CYCLES + 1);

  rggen_arbiter_state        state_r;
  rggen_arbiter_state        state_next_s;
  logic [HOSTS-1:0]          pick_s;
  logic [HOSTS-1:0]          grant_r;
  logic [1:0]                access_r;
  logic [ADDRESS_WIDTH-1:0]  address_r;
  logic [BUS_WIDTH-1:0]      write_data_r;
  logic [STRB_W-1:0]         strobe_r;
  logic [1:0]                status_r;
  logic [BUS_WIDTH-1:0]      read_data_r;
  logic [COUNT_W-1:0]        count_r;
  logic                      timeout_s;
  logic [1:0]                sel_access_s;
  logic [ADDRESS_WIDTH-1:0]  sel_address_s;
  logic [BUS_WIDTH-1:0]      sel_write_data_s;
  logic [STRB_W-1:0]         sel_strobe_s;

  rggen_round_robin_arbiter #(
    .HOSTS (HOSTS)
  ) u_arbiter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_request    (i_host_valid),
    .i_done       (state_r == RESP),
    .i_done_grant (grant_r),
    .o_grant      (pick_s)
  );

  // AND-OR mux of the picked host's command fields.
  always_comb begin
    sel_access_s     = '0;
    sel_address_s    = '0;
    sel_write_data_s = '0;
    sel_strobe_s     = '0;
    for (int h = 0; h < HOSTS; h++) begin
      sel_access_s     = sel_access_s     | ({2{pick_s[h]}}             & i_host_access[h]);
      sel_address_s    = sel_address_s    | ({ADDRESS_WIDTH{pick_s[h]}} & i_host_address[h]);
      sel_write_data_s = sel_write_data_s | ({BUS_WIDTH{pick_s[h]}}     & i_host_write_data[h]);
      sel_strobe_s     = sel_strobe_s     | ({STRB_W{pick_s[h]}}        & i_host_strobe[h]);
    end
  end

  // Timeout fires on the last permitted wait cycle; disabled when zero.
  always_comb begin
    if (TIMEOUT_CYCLES > 0) begin
      timeout_s = (count_r == COUNT_W'(TIMEOUT_CYCLES - 1));
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE/BUSY/RESP transaction sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|i_host_valid) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (i_ready || timeout_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = BUSY;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command latch, response capture and wait counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_r      <= '0;
      access_r     <= '0;
      address_r    <= '0;
      write_data_r <= '0;
      strobe_r     <= '0;
      status_r     <= '0;
      read_data_r  <= '0;
      count_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          count_r <= '0;
          if (|i_host_valid) begin
            grant_r      <= pick_s;
            access_r     <= sel_access_s;
            address_r    <= sel_address_s;
            write_data_r <= sel_write_data_s;
            strobe_r     <= sel_strobe_s;
          end
        end
        BUSY: begin
          count_r <= count_r + COUNT_W'(1'b1);
          if (i_ready) begin
            status_r    <= i_status;
            read_data_r <= (access_r == RGGEN_READ) ? i_read_data : '0;
          end else if (timeout_s) begin
            status_r    <= RGGEN_SLAVE_ERROR;
            read_data_r <= '0;
          end
        end
        RESP: begin
          grant_r <= '0;
          count_r <= '0;
        end
        default: begin
          grant_r <= '0;
          count_r <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state: bus only in BUSY, response lane only in RESP.
  always_comb begin
    o_grant          = grant_r;
    o_valid          = 1'b0;
    o_access         = '0;
    o_address        = '0;
    o_write_data     = '0;
    o_strobe         = '0;
    o_host_ready     = '0;
    o_host_status    = '0;
    o_host_read_data = '0;
    if (state_r == BUSY) begin
      o_valid      = 1'b1;
      o_access     = access_r;
      o_address    = address_r;
      o_write_data = write_data_r;
      o_strobe     = strobe_r;
    end else begin
      o_valid      = 1'b0;
    end
    for (int h = 0; h < HOSTS; h++) begin
      o_host_ready[h]     = (state_r == RESP) && grant_r[h];
      o_host_status[h]    = {2{o_host_ready[h]}} & status_r;
      o_host_read_data[h] = {BUS_WIDTH{o_host_ready[h]}} & read_data_r;
    end
  end

endmodule
